ensemble_vote_scheduler: RTL and testbench
==========================================

// Module: ensemble_vote_scheduler
// PURPOSE
//  Sequences the three-classifier ensemble (gaussian_nb, gradient_boost, mlp).
//  Takes one upstream AXI-Stream of feature vectors, fans each beat out to all three classifier inputs,
//  collects one result beat per classifier per sample, majority-votes the results and emits one result beat per sample.
//  Bounds the number of samples in flight.
//  Sits between the DMA-side stream and the three-lane ensemble wrapper.
// PARAMETERS
//  DATA_WIDTH       32  stream data width (all streams)
//  KEEP_WIDTH        4  tkeep width (DATA_WIDTH/8)
//  CLASS_W           8  class-ID bits taken from result tdata[CLASS_W-1:0]
//  MAX_OUTSTANDING   4  max samples dispatched but not yet voted (>=1)
//  TIE_LANE          0  lane whose result wins when all three differ (0..2)
// PORTS
//  clk            in   1             single clock, all logic rising-edge
//  rst_n          in   1             asynchronous, active-low reset
//  s_axis_tdata   in   DATA_WIDTH    feature beat
//  s_axis_tkeep   in   KEEP_WIDTH    forwarded unchanged
//  s_axis_tvalid  in   1             upstream valid
//  s_axis_tready  out  1             upstream ready
//  s_axis_tlast   in   1             last beat of sample
//  cls_s_tdata    out  3*DATA_WIDTH  to classifier i input, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//  cls_s_tkeep    out  3*KEEP_WIDTH  per-lane keep
//  cls_s_tvalid   out  3             per-lane valid
//  cls_s_tready   in   3             per-lane ready
//  cls_s_tlast    out  3             per-lane last
//  cls_m_tdata    in   3*DATA_WIDTH  classifier i result
//  cls_m_tvalid   in   3             per-lane result valid
//  cls_m_tready   out  3             per-lane result ready
//  m_axis_tdata   out  DATA_WIDTH    {0, agree[2:0], winner[CLASS_W-1:0]}
//  m_axis_tkeep   out  KEEP_WIDTH    all ones while valid
//  m_axis_tvalid  out  1             vote valid
//  m_axis_tready  in   1             downstream ready
//  m_axis_tlast   out  1             always 1 with valid
//  in_flight      out  $clog2(MAX_OUTSTANDING+1)  samples outstanding
//  disagree       out  1             1-cycle pulse when the vote is not unanimous
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - all registered outputs, pending[2:0], res_vld[2:0], in_flight and state are 0; FSM goes to COLLECT; sop=1.
//   - A reset mid-sample drops any partial sample; no recovery beat is sent.
//  Fan-out: one holding register {data,keep,last} plus pending[2:0].
//   - cls_s_tvalid = pending; bit i clears on a lane-i handshake.
//   - s_axis_tready = (pending & ~cls_s_tready)==0 && !gate.
//   - On upstream accept: load the register, pending=3'b111. Same-cycle drain and reload is allowed (full throughput).
//   - Latency: 1 cycle from upstream accept to cls_s_tvalid.
//   - Each lane sees every beat exactly once, in order; a stalled lane stalls upstream only, never the other lanes' current beat.
//  Outstanding gate:
//   - sop=1 before a sample's first beat.
//   - gate = sop && in_flight==MAX_OUTSTANDING. Mid-sample beats are never gated.
//   - in_flight +1 on an accepted tlast beat, -1 on an m_axis handshake; both in the same cycle -> unchanged.
//  Collect:
//   - res[i] captured from cls_m_tdata lane i; cls_m_tready[i] = !res_vld[i].
//   - Each classifier returns exactly one beat per sample; result tlast/tkeep are ignored.
//  FSM:
//   - COLLECT: wait for res_vld==3'b111, then go to VOTE.
//   - VOTE (1 cycle): compute and register the output, pulse disagree if agree!=3'b111, then go to EMIT.
//   - EMIT: m_axis_tvalid=1 with data held stable until m_axis_tready. On the handshake clear res_vld and return to COLLECT.
//   - Minimum 3 cycles from the last result to the next result accept.
//  Vote:
//   - r0==r1 || r0==r2 -> r0; else r1==r2 -> r1; else res[TIE_LANE].
//   - agree[i] = (res[i]==winner). Upper tdata bits are 0.
// STRUCTURE
//  ensemble_pkg: NUM_LANES=3, state enum {COLLECT,VOTE,EMIT}, AGREE_LSB=CLASS_W, field widths.
//  Sub-module ensemble_broadcast: holding register + pending flags + ready logic, parameterised by NUM_LANES.
//  Vote logic, FSM and in_flight counter live in the top.
// TESTING (CLASS_W=8, TIE_LANE=0 unless stated)
//  1 Sample of 4 beats, all lanes ready; results 2,2,5
//    -> one m_axis beat tdata=0x302, tlast=1, disagree pulses once, in_flight 1->0.
//  2 Lane1 cls_s_tready low 5 cycles mid-sample
//    -> s_axis_tready low exactly then; lanes 0/2 get each beat once; all lanes get identical ordered beats.
//  3 Results 1,3,7 -> tdata=0x101. With TIE_LANE=2 -> tdata=0x407.
//  4 MAX_OUTSTANDING=2, results withheld after 2 samples
//    -> in_flight=2, 3rd sample's first beat stalled; release one vote -> accepted next cycle.
//  5 m_axis_tready low 10 cycles in EMIT
//    -> tdata stable, cls_m_tready all 0; then results 4,4,4 -> 0x704, no disagree pulse.
//  6 rst_n pulsed mid-sample (2 of 4 beats sent)
//    -> all outputs 0, in_flight 0; a fresh sample then votes correctly.

Source files
------------

// File: rtl/ensemble_vote_scheduler_pkg.sv
// Shared constants for the ensemble vote scheduler slice.
//   NUM_LANES  : number of classifier lanes fanned out / voted over
//   AGREE_W    : width of the per-lane agreement field in the vote beat
//   ST_*       : FSM state encodings for the result collect/vote/emit sequence
package ensemble_vote_scheduler_pkg;

    localparam int unsigned NUM_LANES = 3;
    localparam int unsigned AGREE_W   = NUM_LANES;

    localparam int unsigned ST_W = 2;
    localparam logic [ST_W-1:0] ST_COLLECT = 2'd0;
    localparam logic [ST_W-1:0] ST_VOTE    = 2'd1;
    localparam logic [ST_W-1:0] ST_EMIT    = 2'd2;

endpackage

// File: rtl/ensemble_vote_scheduler_if.sv
// Stream bundle between the DMA side, the three classifier lanes and the
// vote output.
//   s_axis_*  : upstream feature stream
//   cls_s_*   : per-lane feature streams to the classifiers (lane i at slice i)
//   cls_m_*   : per-lane result streams from the classifiers
//   m_axis_*  : voted result stream
// Modports: slave = scheduler view, master = environment view.
interface ensemble_vote_scheduler_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned KEEP_WIDTH = 4
);
    import ensemble_vote_scheduler_pkg::*;

    logic [DATA_WIDTH-1:0]           s_axis_tdata;
    logic [KEEP_WIDTH-1:0]           s_axis_tkeep;
    logic                            s_axis_tvalid;
    logic                            s_axis_tready;
    logic                            s_axis_tlast;

    logic [NUM_LANES*DATA_WIDTH-1:0] cls_s_tdata;
    logic [NUM_LANES*KEEP_WIDTH-1:0] cls_s_tkeep;
    logic [NUM_LANES-1:0]            cls_s_tvalid;
    logic [NUM_LANES-1:0]            cls_s_tready;
    logic [NUM_LANES-1:0]            cls_s_tlast;

    logic [NUM_LANES*DATA_WIDTH-1:0] cls_m_tdata;
    logic [NUM_LANES-1:0]            cls_m_tvalid;
    logic [NUM_LANES-1:0]            cls_m_tready;

    logic [DATA_WIDTH-1:0]           m_axis_tdata;
    logic [KEEP_WIDTH-1:0]           m_axis_tkeep;
    logic                            m_axis_tvalid;
    logic                            m_axis_tready;
    logic                            m_axis_tlast;

    modport slave (
        input  s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast,
        output s_axis_tready,
        output cls_s_tdata, cls_s_tkeep, cls_s_tvalid, cls_s_tlast,
        input  cls_s_tready,
        input  cls_m_tdata, cls_m_tvalid,
        output cls_m_tready,
        output m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast,
        input  m_axis_tready
    );

    modport master (
        output s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast,
        input  s_axis_tready,
        input  cls_s_tdata, cls_s_tkeep, cls_s_tvalid, cls_s_tlast,
        output cls_s_tready,
        output cls_m_tdata, cls_m_tvalid,
        input  cls_m_tready,
        input  m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast,
        output m_axis_tready
    );

endinterface

// File: rtl/ensemble_vote_scheduler_broadcast.sv
// One-deep broadcast buffer: holds a single upstream beat and presents it to
// every lane until each lane has taken it.
//   clk, rst_n      : clock, async active-low reset
//   i_data/keep/last/valid : upstream beat
//   i_gate          : blocks acceptance of a new beat (outstanding limit)
//   o_ready         : upstream ready
//   o_accept        : upstream handshake this cycle
//   o_lane_*        : per-lane replicated beat, o_lane_valid = pending flags
//   i_lane_ready    : per-lane ready
module ensemble_vote_scheduler_broadcast #(
    parameter int unsigned NUM_LANES  = 3,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned KEEP_WIDTH = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [DATA_WIDTH-1:0]           i_data,
    input  logic [KEEP_WIDTH-1:0]           i_keep,
    input  logic                            i_last,
    input  logic                            i_valid,
    input  logic                            i_gate,
    output logic                            o_ready,
    output logic                            o_accept,
    output logic [NUM_LANES*DATA_WIDTH-1:0] o_lane_data,
    output logic [NUM_LANES*KEEP_WIDTH-1:0] o_lane_keep,
    output logic [NUM_LANES-1:0]            o_lane_valid,
    output logic [NUM_LANES-1:0]            o_lane_last,
    input  logic [NUM_LANES-1:0]            i_lane_ready
);

    logic [DATA_WIDTH-1:0] r_data;
    logic [KEEP_WIDTH-1:0] r_keep;
    logic                  r_last;
    logic [NUM_LANES-1:0]  r_pending;
    logic                  w_ready;
    logic                  w_accept;

    // Ready once every lane still holding the current beat takes it this
    // cycle, so drain and reload can happen on the same edge.
    assign w_ready  = ((r_pending & ~i_lane_ready) == '0) && !i_gate;
    assign w_accept = i_valid && w_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data    <= '0;
            r_keep    <= '0;
            r_last    <= 1'b0;
            r_pending <= '0;
        end else if (w_accept) begin
            r_data    <= i_data;
            r_keep    <= i_keep;
            r_last    <= i_last;
            r_pending <= '1;
        end else begin
            r_pending <= r_pending & ~i_lane_ready;
        end
    end

    assign o_ready      = w_ready;
    assign o_accept     = w_accept;
    assign o_lane_data  = {NUM_LANES{r_data}};
    assign o_lane_keep  = {NUM_LANES{r_keep}};
    assign o_lane_last  = {NUM_LANES{r_last}};
    assign o_lane_valid = r_pending;

endmodule

// File: rtl/ensemble_vote_scheduler.sv
// Ensemble vote scheduler: fans each upstream feature beat out to three
// classifiers, collects one result per classifier per sample, majority-votes
// and emits one result beat {0, agree[2:0], winner} per sample. Limits the
// number of samples dispatched but not yet voted.
//   clk, rst_n : clock, async active-low reset
//   bus        : stream bundle (slave modport)
//   in_flight  : samples dispatched and not yet voted out
//   disagree   : one-cycle pulse when a vote is not unanimous
module ensemble_vote_scheduler
    import ensemble_vote_scheduler_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned KEEP_WIDTH      = 4,
    parameter int unsigned CLASS_W         = 8,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned TIE_LANE        = 0
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    ensemble_vote_scheduler_if.slave             bus,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] in_flight,
    output logic                                 disagree
);

    localparam int unsigned IFW       = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned AGREE_LSB = CLASS_W;

    logic                  w_accept;
    logic                  w_gate;
    logic                  w_m_hs;
    logic                  r_sop;
    logic [IFW-1:0]        r_in_flight;
    logic [ST_W-1:0]       r_state;
    logic [NUM_LANES-1:0]  r_res_vld;
    logic [CLASS_W-1:0]    r_res [NUM_LANES];
    logic [DATA_WIDTH-1:0] r_m_tdata;
    logic                  r_m_tvalid;
    logic                  r_disagree;
    logic [CLASS_W-1:0]    w_winner;
    logic [AGREE_W-1:0]    w_agree;
    logic [DATA_WIDTH-1:0] w_vote_data;
    logic                  w_unused;

    assign w_unused = ^bus.cls_m_tdata;

    // Only the first beat of a sample is held back; a sample already started
    // always completes so lanes never see a torn sample.
    assign w_gate = r_sop && (r_in_flight == IFW'(MAX_OUTSTANDING));
    assign w_m_hs = r_m_tvalid && bus.m_axis_tready;

    ensemble_vote_scheduler_broadcast #(
        .NUM_LANES  (NUM_LANES),
        .DATA_WIDTH (DATA_WIDTH),
        .KEEP_WIDTH (KEEP_WIDTH)
    ) u_broadcast (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_data       (bus.s_axis_tdata),
        .i_keep       (bus.s_axis_tkeep),
        .i_last       (bus.s_axis_tlast),
        .i_valid      (bus.s_axis_tvalid),
        .i_gate       (w_gate),
        .o_ready      (bus.s_axis_tready),
        .o_accept     (w_accept),
        .o_lane_data  (bus.cls_s_tdata),
        .o_lane_keep  (bus.cls_s_tkeep),
        .o_lane_valid (bus.cls_s_tvalid),
        .o_lane_last  (bus.cls_s_tlast),
        .i_lane_ready (bus.cls_s_tready)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sop       <= 1'b1;
            r_in_flight <= '0;
        end else begin
            if (w_accept) begin
                r_sop <= bus.s_axis_tlast;
            end
            case ({w_accept && bus.s_axis_tlast, w_m_hs})
                2'b10:   r_in_flight <= r_in_flight + IFW'(1);
                2'b01:   r_in_flight <= r_in_flight - IFW'(1);
                default: r_in_flight <= r_in_flight;
            endcase
        end
    end

    // Result capture: each lane holds one result until the vote is emitted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res_vld <= '0;
            for (int unsigned i = 0; i < NUM_LANES; i++) begin
                r_res[i] <= '0;
            end
        end else if (r_state == ST_EMIT && w_m_hs) begin
            r_res_vld <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_LANES; i++) begin
                if (bus.cls_m_tvalid[i] && !r_res_vld[i]) begin
                    r_res[i]     <= bus.cls_m_tdata[i*DATA_WIDTH +: CLASS_W];
                    r_res_vld[i] <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_winner = r_res[TIE_LANE];
        if (r_res[0] == r_res[1] || r_res[0] == r_res[2]) begin
            w_winner = r_res[0];
        end else if (r_res[1] == r_res[2]) begin
            w_winner = r_res[1];
        end
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            w_agree[i] = (r_res[i] == w_winner);
        end
        w_vote_data                          = '0;
        w_vote_data[CLASS_W-1:0]             = w_winner;
        w_vote_data[AGREE_LSB +: AGREE_W]    = w_agree;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_COLLECT;
            r_m_tdata  <= '0;
            r_m_tvalid <= 1'b0;
            r_disagree <= 1'b0;
        end else begin
            r_disagree <= 1'b0;
            case (r_state)
                ST_COLLECT: begin
                    if (r_res_vld == '1) begin
                        r_state <= ST_VOTE;
                    end
                end
                ST_VOTE: begin
                    r_m_tdata  <= w_vote_data;
                    r_m_tvalid <= 1'b1;
                    r_disagree <= (w_agree != '1);
                    r_state    <= ST_EMIT;
                end
                ST_EMIT: begin
                    if (bus.m_axis_tready) begin
                        r_m_tvalid <= 1'b0;
                        r_state    <= ST_COLLECT;
                    end
                end
                default: r_state <= ST_COLLECT;
            endcase
        end
    end

    assign bus.cls_m_tready  = ~r_res_vld;
    assign bus.m_axis_tdata  = r_m_tdata;
    assign bus.m_axis_tvalid = r_m_tvalid;
    assign bus.m_axis_tkeep  = {KEEP_WIDTH{r_m_tvalid}};
    assign bus.m_axis_tlast  = r_m_tvalid;
    assign in_flight         = r_in_flight;
    assign disagree          = r_disagree;

endmodule

// File: tb/tb_ensemble_vote_scheduler.sv
// Scoreboard bench for ensemble_vote_scheduler. A second instance with
// TIE_LANE=2 shadows the main one on identical inputs so tie-break results for
// both settings are checked on every vote.
module tb_ensemble_vote_scheduler;

    localparam int unsigned DW  = 32;
    localparam int unsigned KW  = 4;
    localparam int unsigned TMO = 300;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] in_flight, in_flight2;
    logic       disagree, disagree2;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    logic [63:0] beats [$];
    int unsigned lane_rd [3];
    logic [31:0] exp_q  [$];
    logic [31:0] exp_q2 [$];
    logic        exp_dis [$];
    int unsigned n_pulses = 0;
    int unsigned exp_pulses = 0;
    logic        prev_v = 1'b0;

    always #5 clk = ~clk;

    ensemble_vote_scheduler_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW)) bus ();
    ensemble_vote_scheduler_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW)) bus2 ();

    assign bus2.s_axis_tdata  = bus.s_axis_tdata;
    assign bus2.s_axis_tkeep  = bus.s_axis_tkeep;
    assign bus2.s_axis_tvalid = bus.s_axis_tvalid;
    assign bus2.s_axis_tlast  = bus.s_axis_tlast;
    assign bus2.cls_s_tready  = bus.cls_s_tready;
    assign bus2.cls_m_tdata   = bus.cls_m_tdata;
    assign bus2.cls_m_tvalid  = bus.cls_m_tvalid;
    assign bus2.m_axis_tready = bus.m_axis_tready;

    ensemble_vote_scheduler #(
        .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .CLASS_W(8),
        .MAX_OUTSTANDING(2), .TIE_LANE(0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave),
        .in_flight(in_flight), .disagree(disagree)
    );

    ensemble_vote_scheduler #(
        .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .CLASS_W(8),
        .MAX_OUTSTANDING(2), .TIE_LANE(2)
    ) dut_tie2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2.slave),
        .in_flight(in_flight2), .disagree(disagree2)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Winner: lowest-numbered lane whose class matches another lane, else the tie lane.
    function automatic logic [31:0] vote_model(input logic [7:0] r0, input logic [7:0] r1,
                                               input logic [7:0] r2, input int unsigned tie);
        logic [7:0] r [3];
        logic [7:0] w;
        logic [2:0] ag;
        r[0] = r0; r[1] = r1; r[2] = r2;
        w = r[tie];
        for (int j = 1; j >= 0; j--) begin
            for (int k = 0; k < 3; k++) begin
                if (k != j && r[k] == r[j]) w = r[j];
            end
        end
        for (int k = 0; k < 3; k++) ag[k] = (r[k] == w);
        return {21'b0, ag, w};
    endfunction

    task automatic send_sample(input int unsigned nb, input bit with_last);
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
        bit          acc;
        int unsigned n;
        for (int unsigned b = 0; b < nb; b++) begin
            d = $urandom;
            k = 4'($urandom);
            l = with_last && (b == nb - 1);
            bus.s_axis_tdata  = d;
            bus.s_axis_tkeep  = k;
            bus.s_axis_tlast  = l;
            bus.s_axis_tvalid = 1'b1;
            acc = 1'b0;
            n = 0;
            while (!acc && n < TMO) begin
                @(negedge clk);
                if (bus.s_axis_tready) begin
                    acc = 1'b1;
                    beats.push_back({27'b0, l, k, d});
                end
                @(posedge clk); #1;
                n++;
            end
            chk("up_accept", 64'(acc), 64'd1);
        end
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tlast  = 1'b0;
    endtask

    task automatic give_results(input logic [7:0] r0, input logic [7:0] r1, input logic [7:0] r2);
        logic [2:0]  left;
        logic [2:0]  nxt;
        int unsigned n;
        logic        dis;
        exp_q.push_back(vote_model(r0, r1, r2, 0));
        exp_q2.push_back(vote_model(r0, r1, r2, 2));
        dis = !(r0 == r1 && r1 == r2);
        exp_dis.push_back(dis);
        if (dis) exp_pulses++;
        bus.cls_m_tdata  = {24'($urandom), r2, 24'($urandom), r1, 24'($urandom), r0};
        bus.cls_m_tvalid = 3'b111;
        left = 3'b111;
        n = 0;
        while (left != 3'b000 && n < TMO) begin
            @(negedge clk);
            nxt = left & ~bus.cls_m_tready;
            @(posedge clk); #1;
            left = nxt;
            bus.cls_m_tvalid = left;
            n++;
        end
        chk("res_accept", 64'(left), 64'd0);
    endtask

    task automatic drain();
        int unsigned n = 0;
        while ((exp_q.size() != 0 || bus.m_axis_tvalid) && n < TMO) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1;
        chk("drain", 64'(exp_q.size()), 64'd0);
    endtask

    // Lane scoreboard: every lane must see every accepted beat once, in order.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 3; i++) begin
                if (bus.cls_s_tvalid[i] && bus.cls_s_tready[i]) begin
                    if (lane_rd[i] < beats.size()) begin
                        chk("lane_beat",
                            {27'b0, bus.cls_s_tlast[i], bus.cls_s_tkeep[i*KW +: KW],
                             bus.cls_s_tdata[i*DW +: DW]},
                            beats[lane_rd[i]]);
                        lane_rd[i]++;
                    end else begin
                        chk("lane_extra", 64'd1, 64'd0);
                    end
                end
            end
        end
    end

    // Vote scoreboard.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_v = 1'b0;
        end else begin
            if (disagree) n_pulses++;
            if (bus.m_axis_tvalid && !prev_v && exp_dis.size() != 0) begin
                chk("disagree", 64'(disagree), 64'(exp_dis[0]));
            end
            if (bus.m_axis_tvalid && bus.m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    chk("vote_unexpected", 64'd1, 64'd0);
                end else begin
                    chk("vote_tdata", 64'(bus.m_axis_tdata), 64'(exp_q.pop_front()));
                    chk("vote_tdata_tie2", 64'(bus2.m_axis_tdata), 64'(exp_q2.pop_front()));
                    chk("vote_tlast", 64'(bus.m_axis_tlast), 64'd1);
                    chk("vote_tkeep", 64'(bus.m_axis_tkeep), 64'hf);
                    void'(exp_dis.pop_front());
                end
            end
            prev_v = bus.m_axis_tvalid;
        end
    end

    initial begin
        int unsigned n;
        for (int i = 0; i < 3; i++) lane_rd[i] = 0;
        bus.s_axis_tdata  = '0;
        bus.s_axis_tkeep  = '0;
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tlast  = 1'b0;
        bus.cls_s_tready  = 3'b111;
        bus.cls_m_tdata   = '0;
        bus.cls_m_tvalid  = 3'b000;
        bus.m_axis_tready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_m_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
        chk("rst_m_tdata", 64'(bus.m_axis_tdata), 64'd0);
        chk("rst_m_tkeep", 64'(bus.m_axis_tkeep), 64'd0);
        chk("rst_cls_s_tvalid", 64'(bus.cls_s_tvalid), 64'd0);
        chk("rst_in_flight", 64'(in_flight), 64'd0);
        chk("rst_disagree", 64'(disagree), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: 4-beat sample, results 2,2,5
        send_sample(4, 1'b1);
        @(negedge clk);
        chk("t1_in_flight_1", 64'(in_flight), 64'd1);
        @(posedge clk); #1;
        give_results(8'd2, 8'd2, 8'd5);
        drain();
        @(negedge clk);
        chk("t1_in_flight_0", 64'(in_flight), 64'd0);
        @(posedge clk); #1;

        // 2: lane 1 stalls for 5 cycles mid-sample
        fork
            send_sample(6, 1'b1);
            begin
                @(posedge clk); #1;
                @(posedge clk); #1;
                bus.cls_s_tready = 3'b101;
                repeat (5) begin
                    @(negedge clk);
                    chk("t2_stall_ready", 64'(bus.s_axis_tready), 64'd0);
                end
                @(posedge clk); #1;
                bus.cls_s_tready = 3'b111;
                @(negedge clk);
                chk("t2_resume_ready", 64'(bus.s_axis_tready), 64'd1);
            end
        join
        give_results(8'd6, 8'd6, 8'd6);
        drain();

        // 3: all results differ
        send_sample(2, 1'b1);
        give_results(8'd1, 8'd3, 8'd7);
        drain();
        send_sample(1, 1'b1);
        give_results(8'd9, 8'd4, 8'd4);
        drain();

        // 4: outstanding limit of 2
        send_sample(3, 1'b1);
        send_sample(2, 1'b1);
        @(negedge clk);
        chk("t4_in_flight_2", 64'(in_flight), 64'd2);
        @(posedge clk); #1;
        fork
            send_sample(3, 1'b1);
            begin
                repeat (5) begin
                    @(negedge clk);
                    chk("t4_gated", 64'(bus.s_axis_tready), 64'd0);
                end
                @(posedge clk); #1;
                give_results(8'd5, 8'd5, 8'd5);
                n = 0;
                while (!(bus.m_axis_tvalid && bus.m_axis_tready) && n < TMO) begin
                    @(negedge clk);
                    n++;
                end
                @(negedge clk);
                chk("t4_release_ready", 64'(bus.s_axis_tready), 64'd1);
                chk("t4_release_in_flight", 64'(in_flight), 64'd1);
            end
        join
        give_results(8'd3, 8'd1, 8'd1);
        give_results(8'd2, 8'd7, 8'd2);
        drain();

        // 5: downstream stall in EMIT
        bus.m_axis_tready = 1'b0;
        send_sample(2, 1'b1);
        give_results(8'd9, 8'd9, 8'd1);
        n = 0;
        while (!bus.m_axis_tvalid && n < TMO) begin
            @(negedge clk);
            n++;
        end
        repeat (10) begin
            @(negedge clk);
            chk("t5_hold_tdata", 64'(bus.m_axis_tdata), 64'(vote_model(8'd9, 8'd9, 8'd1, 0)));
            chk("t5_cls_m_tready", 64'(bus.cls_m_tready), 64'd0);
        end
        @(posedge clk); #1;
        bus.m_axis_tready = 1'b1;
        drain();
        send_sample(3, 1'b1);
        give_results(8'd4, 8'd4, 8'd4);
        drain();

        // 6: reset mid-sample
        send_sample(2, 1'b0);
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        @(negedge clk);
        chk("t6_m_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
        chk("t6_cls_s_tvalid", 64'(bus.cls_s_tvalid), 64'd0);
        chk("t6_in_flight", 64'(in_flight), 64'd0);
        chk("t6_disagree", 64'(disagree), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send_sample(4, 1'b1);
        @(negedge clk);
        chk("t6_in_flight_1", 64'(in_flight), 64'd1);
        @(posedge clk); #1;
        give_results(8'd3, 8'd8, 8'd3);
        drain();

        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("lane_count", 64'(lane_rd[i]), 64'(beats.size()));
        end
        chk("disagree_pulses", 64'(n_pulses), 64'(exp_pulses));
        chk("votes_pending", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
